// File: rtl/sr_flop_bank.sv
// Bank of WIDTH independent SR flip-flops with selectable conflict response,
// optional rising-edge triggering and a saturating set/clear conflict counter.

module sr_flop_lane #(
  parameter int MODE = 0,
  parameter int EDGE = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic set_i,
  input  logic clr_i,
  output logic q_o,
  output logic conflict_o,
  output logic sc_o
);
  logic set_hist_q, clr_hist_q;
  logic q_q, q_d;
  logic cf_q, cf_d;
  logic s, c;

  always_comb begin
    s = (EDGE != 0) ? (set_i & ~set_hist_q) : set_i;
    c = (EDGE != 0) ? (clr_i & ~clr_hist_q) : clr_i;
    q_d = q_q;
    if (en_i) begin
      unique case ({s, c})
        2'b10: q_d = 1'b1;
        2'b01: q_d = 1'b0;
        2'b11: begin
          if      (MODE == 0) q_d = 1'b0;
          else if (MODE == 1) q_d = 1'b1;
          else if (MODE == 2) q_d = q_q;
          else                q_d = ~q_q;
        end
        default: q_d = q_q;
      endcase
    end
    cf_d = en_i & s & c;
  end

  // History runs every clock, so edges seen while disabled are consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      set_hist_q <= 1'b0;
      clr_hist_q <= 1'b0;
      q_q        <= 1'b0;
      cf_q       <= 1'b0;
    end else begin
      set_hist_q <= set_i;
      clr_hist_q <= clr_i;
      q_q        <= q_d;
      cf_q       <= cf_d;
    end
  end

  assign q_o        = q_q;
  assign conflict_o = cf_q;
  assign sc_o       = cf_d;
endmodule

module sr_flop_bank #(
  parameter int WIDTH = 8,
  parameter int MODE  = 0,
  parameter int EDGE  = 0,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] set,
  input  logic [WIDTH-1:0] clr,
  input  logic             clr_cnt,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n,
  output logic [WIDTH-1:0] conflict,
  output logic [CNT_W-1:0] conflict_cnt
);
  if (MODE < 0 || MODE > 3 || WIDTH < 1 || CNT_W < 2) begin : g_bad_param
    $error("sr_flop_bank: illegal parameters MODE=%0d WIDTH=%0d CNT_W=%0d", MODE, WIDTH, CNT_W);
  end

  logic [WIDTH-1:0] sc;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    sr_flop_lane #(.MODE(MODE), .EDGE(EDGE)) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .en_i      (en),
      .set_i     (set[i]),
      .clr_i     (clr[i]),
      .q_o       (q[i]),
      .conflict_o(conflict[i]),
      .sc_o      (sc[i])
    );
  end

  // sc already includes en, so any lane conflicting counts once per cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt)                  cnt_d = '0;
    else if (|sc && cnt_q != '1)  cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign q_n          = ~q;
  assign conflict_cnt = cnt_q;
endmodule

// File: tb/tb_sr_flop_bank.sv
// Directed bench: four conflict-mode banks, one edge-mode bank and one
// narrow-counter bank share the same stimulus; each phase checks its target.

module tb_sr_flop_bank;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b1;
  logic [3:0] set = '0, clr = '0;
  logic       clr_cnt = 1'b0;

  logic [3:0] qm [4], qnm [4], cfm [4];
  logic [7:0] cntm [4];
  logic [3:0] q_e, qn_e, cf_e;
  logic [7:0] cnt_e;
  logic [3:0] q_s, qn_s, cf_s;
  logic [1:0] cnt_s;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  for (genvar m = 0; m < 4; m++) begin : g_mode
    sr_flop_bank #(.WIDTH(4), .MODE(m), .EDGE(0), .CNT_W(8)) u_dut (
      .clk(clk), .rst_n(rst_n), .en(en), .set(set), .clr(clr), .clr_cnt(clr_cnt),
      .q(qm[m]), .q_n(qnm[m]), .conflict(cfm[m]), .conflict_cnt(cntm[m])
    );
  end

  sr_flop_bank #(.WIDTH(4), .MODE(0), .EDGE(1), .CNT_W(8)) u_edge (
    .clk(clk), .rst_n(rst_n), .en(en), .set(set), .clr(clr), .clr_cnt(clr_cnt),
    .q(q_e), .q_n(qn_e), .conflict(cf_e), .conflict_cnt(cnt_e)
  );

  sr_flop_bank #(.WIDTH(4), .MODE(0), .EDGE(0), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .set(set), .clr(clr), .clr_cnt(clr_cnt),
    .q(q_s), .q_n(qn_s), .conflict(cf_s), .conflict_cnt(cnt_s)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // async reset, held across edges
    #2 rst_n = 1'b0;
    #1;
    chk("rst_q",     32'(qm[0]),   32'h0);
    chk("rst_qn",    32'(qnm[0]),  32'hf);
    chk("rst_cf",    32'(cfm[0]),  32'h0);
    chk("rst_cnt",   32'(cntm[0]), 32'h0);
    chk("rst_q_e",   32'(q_e),     32'h0);
    chk("rst_cnt_s", 32'(cnt_s),   32'h0);
    step();
    step();
    #3 rst_n = 1'b1;
    step();
    chk("post_rst_q", 32'(qm[0]), 32'h0);

    // basic set then clear
    set = 4'b0001; step();
    chk("set_q",  32'(qm[0]),  32'h1);
    chk("set_qn", 32'(qnm[0]), 32'he);
    set = 4'b0000; clr = 4'b0001; step();
    chk("clr_q",  32'(qm[0]),  32'h0);
    chk("clr_qn", 32'(qnm[0]), 32'hf);
    clr = 4'b0000;

    // conflict modes: ch0 set, then two cycles of set=clr=1
    set = 4'b0001; step();
    for (int m = 0; m < 4; m++) chk($sformatf("pre_cf_q_m%0d", m), 32'(qm[m]), 32'h1);
    clr = 4'b0001; step();
    chk("cf1_q_m0", 32'(qm[0]), 32'h0);
    chk("cf1_q_m1", 32'(qm[1]), 32'h1);
    chk("cf1_q_m2", 32'(qm[2]), 32'h1);
    chk("cf1_q_m3", 32'(qm[3]), 32'h0);
    for (int m = 0; m < 4; m++) chk($sformatf("cf1_flag_m%0d", m), 32'(cfm[m]), 32'h1);
    step();
    chk("cf2_q_m0", 32'(qm[0]), 32'h0);
    chk("cf2_q_m1", 32'(qm[1]), 32'h1);
    chk("cf2_q_m2", 32'(qm[2]), 32'h1);
    chk("cf2_q_m3", 32'(qm[3]), 32'h1);
    for (int m = 0; m < 4; m++) begin
      chk($sformatf("cf2_flag_m%0d", m), 32'(cfm[m]),  32'h1);
      chk($sformatf("cf2_cnt_m%0d", m),  32'(cntm[m]), 32'd2);
    end
    set = 4'b0000; clr = 4'b0000; step();
    chk("cf_pulse_end", 32'(cfm[0]), 32'h0);

    // edge mode: clear, hold set[1] five cycles, clr[1] pulse in cycle 3
    clr = 4'b1111; step();
    clr = 4'b0000; step();
    chk("edge_clear", 32'(q_e), 32'h0);
    set = 4'b0010; step(); chk("edge_c1", 32'(q_e[1]), 32'h1);
    step();                chk("edge_c2", 32'(q_e[1]), 32'h1);
    clr = 4'b0010; step(); chk("edge_c3", 32'(q_e[1]), 32'h0);
    clr = 4'b0000; step(); chk("edge_c4", 32'(q_e[1]), 32'h0);
    step();                chk("edge_c5", 32'(q_e[1]), 32'h0);
    set = 4'b0000; step(); chk("edge_low", 32'(q_e[1]), 32'h0);
    set = 4'b0010; step(); chk("edge_rise", 32'(q_e[1]), 32'h1);
    set = 4'b0000;

    // enable gating and 2-bit counter saturation
    clr_cnt = 1'b1; clr = 4'b1111; step();
    clr_cnt = 1'b0; clr = 4'b0000;
    chk("sat_start_q",   32'(q_s),   32'h0);
    chk("sat_start_cnt", 32'(cnt_s), 32'h0);
    en = 1'b0; set = 4'b1111; step();
    chk("en0_q",  32'(q_s),  32'h0);
    chk("en0_cf", 32'(cf_s), 32'h0);
    clr = 4'b1111; step();
    chk("en0_cf_conf",  32'(cf_s),  32'h0);
    chk("en0_cnt_conf", 32'(cnt_s), 32'h0);
    en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("sat_cnt_%0d", k), 32'(cnt_s), (k < 3) ? 32'(k + 1) : 32'd3);
      chk($sformatf("sat_cf_%0d", k),  32'(cf_s),  32'hf);
    end
    clr_cnt = 1'b1; step();
    chk("clrcnt_win", 32'(cnt_s), 32'h0);
    clr_cnt = 1'b0; set = 4'b0101; clr = 4'b0000; step();
    chk("en1_q", 32'(q_s), 32'h5);
    en = 1'b0; set = 4'b0000; clr = 4'b1111; step();
    chk("en0_hold_q", 32'(q_s), 32'h5);
    en = 1'b1; clr = 4'b0000;

    // async reset mid-operation (set-dominant bank reaches q=1111, cnt=2)
    clr_cnt = 1'b1; step();
    clr_cnt = 1'b0; set = 4'b1111; clr = 4'b1111; step(); step();
    chk("pre_arst_q",   32'(qm[1]),   32'hf);
    chk("pre_arst_cf",  32'(cfm[1]),  32'hf);
    chk("pre_arst_cnt", 32'(cntm[1]), 32'd2);
    clr = 4'b0000;
    #3 rst_n = 1'b0;
    #1;
    chk("arst_q",   32'(qm[1]),   32'h0);
    chk("arst_qn",  32'(qnm[1]),  32'hf);
    chk("arst_cf",  32'(cfm[1]),  32'h0);
    chk("arst_cnt", 32'(cntm[1]), 32'h0);
    chk("arst_q_e", 32'(q_e),     32'h0);
    step();
    chk("arst_held_q_e", 32'(q_e), 32'h0);
    #3 rst_n = 1'b1;
    step();
    chk("arst_rel_q_e", 32'(q_e),   32'hf);
    chk("arst_rel_q",   32'(qm[1]), 32'hf);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/sr_flop_bank.md
Name: sr_flop_bank

Overview:
- Clocked, parametrised successor to the gate-level SR latch: a bank of WIDTH independent SR flip-flops sharing one clock.
- Each channel has a selectable response to simultaneous set/clear and an optional rising-edge trigger mode.
- Set/clear conflicts are flagged per channel and tallied in a saturating counter for debug.
- Used wherever sticky status bits (interrupt pending, error latched) are needed.

Parameters:
WIDTH, 8, number of independent SR channels (>=1)
MODE, 0, response to effective set=clr=1: 0 reset-dominant, 1 set-dominant, 2 hold, 3 toggle
EDGE, 0, 0 = level-sensitive set/clr; 1 = act only on rising edge of set/clr
CNT_W, 8, width of conflict counter (>=2)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  update enable; 0 freezes q and counter
set  input  WIDTH  per-channel set request
clr  input  WIDTH  per-channel clear request
clr_cnt  input  1  synchronous clear of conflict_cnt
q  output  WIDTH  registered channel state
q_n  output  WIDTH  bitwise complement of q (combinational from q)
conflict  output  WIDTH  registered per-channel flag: effective set and clr both 1 in previous enabled cycle
conflict_cnt  output  CNT_W  saturating count of enabled cycles with any conflict

Behaviour:
- Reset (rst_n=0, asynchronous, immediate): q=0, q_n=all ones, conflict=0, conflict_cnt=0, edge history regs set_d=clr_d=0. Release is synchronous to the next rising clk.
- Effective requests:
  - EDGE=0: s=set, c=clr.
  - EDGE=1: s=set & ~set_d, c=clr & ~clr_d.
  - set_d/clr_d capture set/clr every clock regardless of en, so edges arriving while en=0 are lost.
  - First cycle after reset: a set already high counts as a rising edge.
- Per channel i, on the rising clk with en=1:
  - s=1, c=0: q[i]<=1.
  - s=0, c=1: q[i]<=0.
  - s=0, c=0: hold.
  - s=1, c=1, by MODE: 0 -> 0; 1 -> 1; 2 -> hold; 3 -> ~q[i].
- Latency: one clock from request to q. q_n tracks q with no extra cycle.
- conflict[i]<= en & s[i] & c[i] every clock. It is a one-cycle pulse aligned with the q update and clears to 0 on any cycle with en=0.
- conflict_cnt update, highest priority first:
  - clr_cnt=1: <=0, regardless of en.
  - en=1 and |(s&c): +1, saturating at 2^CNT_W-1 (no wrap).
  - otherwise: hold.
  - Any number of channels conflicting in one cycle adds exactly 1.
- en=0: q, conflict_cnt frozen (except clr_cnt); conflict<=0.
- Reset asserted mid-operation overrides everything immediately. No pending request survives reset.
- Illegal MODE values (>3) are not supported. Elaboration shall fail via parameter check.

Test Plan:
- Reset/basic, WIDTH=4, MODE=0, EDGE=0: rst_n low then high; set=4'b0001 one cycle, then clr=4'b0001 one cycle -> q=0000 after reset, q=0001 one clk after set, q=0000 one clk after clr, q_n always ~q.
- Conflict modes, one bench per MODE 0..3: q=1 on ch0, then set=clr=1 for 2 cycles -> MODE0: q[0]=0,0; MODE1: 1,1; MODE2: 1,1; MODE3: 0 then 1. conflict[0]=1 both cycles, conflict_cnt=2.
- Edge mode, EDGE=1: hold set[1]=1 for 5 cycles after q cleared, pulse clr[1] in cycle 3 -> q[1]=1 after cycle 1, 0 after cycle 3, stays 0 (no new set edge); set low then high -> q[1]=1.
- Enable/counter saturation, CNT_W=2: en=0 with set=1 -> q unchanged, conflict=0. en=1 with all channels conflicting for 5 cycles -> conflict_cnt 1,2,3,3,3. clr_cnt=1 together with a conflict -> conflict_cnt=0.
- Async reset mid-operation: q=1111, conflict_cnt=2; drop rst_n between clock edges -> q, conflict, conflict_cnt zero before next edge; with EDGE=1 and set held high across release -> q set one clk after first post-reset edge.
